// File: rtl/hazard_pkg.sv
// Shared encodings and helpers for the hazard unit: forward selects, FSM states,
// the MEM/WB shadow record and the register-match / saturating-increment functions.
package hazard_pkg;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_e;

    typedef enum logic {
        RUN    = 1'b0,
        BFLUSH = 1'b1
    } state_e;

    typedef struct packed {
        logic       reg_write;
        logic       mem_to_reg;
        logic [4:0] write_reg;
    } shadow_t;

    localparam logic [15:0] CNT_MAX = 16'hFFFF;

    // A stage produces src only if it writes a real register; $0 never matches.
    function automatic logic reg_hit(input logic wr_en, input logic [4:0] dst,
                                     input logic [4:0] src);
        return wr_en && (dst != 5'd0) && (dst == src);
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] value, input logic en);
        return (en && (value != CNT_MAX)) ? value + 16'd1 : value;
    endfunction

endpackage

// File: rtl/hazard_if.sv
// Bundle of the hazard unit's pipeline-facing signals; master drives the pipeline
// state into the unit, slave is the hazard unit's view.
interface hazard_if;
    logic [4:0]  Rs_id, Rt_id;
    logic        UseRs_id, UseRt_id;
    logic [4:0]  Rs_ex, Rt_ex;
    logic        RegWrite_ex, MemtoReg_ex;
    logic [4:0]  WriteReg_ex;
    logic        BranchTaken_ex;
    logic        Stall;
    logic        Flush_IFID, Flush_IDEX;
    logic [1:0]  ForwardA, ForwardB;
    logic [15:0] StallCount, FlushCount;

    modport master (
        output Rs_id, Rt_id, UseRs_id, UseRt_id, Rs_ex, Rt_ex,
               RegWrite_ex, MemtoReg_ex, WriteReg_ex, BranchTaken_ex,
        input  Stall, Flush_IFID, Flush_IDEX, ForwardA, ForwardB,
               StallCount, FlushCount
    );

    modport slave (
        input  Rs_id, Rt_id, UseRs_id, UseRt_id, Rs_ex, Rt_ex,
               RegWrite_ex, MemtoReg_ex, WriteReg_ex, BranchTaken_ex,
        output Stall, Flush_IFID, Flush_IDEX, ForwardA, ForwardB,
               StallCount, FlushCount
    );
endinterface

// File: rtl/hazard_shadow.sv
// MEM/WB shadow of the EX write-back controls, advanced every cycle so the
// hazard unit knows which registers the two older instructions will write.
module hazard_shadow
    import hazard_pkg::*;
(
    input  logic    clk,
    input  logic    rst_n,
    input  shadow_t ex_i,
    output shadow_t mem_o,
    output shadow_t wb_o
);

    shadow_t mem_q, wb_q;

    // NOTE: non-blocking assignments make wb_q take the old mem_q, giving a true shift.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem_q <= '0;
            wb_q  <= '0;
        end else begin
            mem_q <= ex_i;
            wb_q  <= mem_q;
        end
    end

    assign mem_o = mem_q;
    assign wb_o  = wb_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard unit: forwarding selects, load-use stall, taken-branch flush FSM
// and saturating stall/flush counters. Define HAZARD_FORWARD_EN to enable forwarding.
module hazard_ctrl
    import hazard_pkg::*;
(
    input  logic        CLOCK,
    input  logic        RESET_N,
    input  logic [4:0]  Rs_id,
    input  logic [4:0]  Rt_id,
    input  logic        UseRs_id,
    input  logic        UseRt_id,
    input  logic [4:0]  Rs_ex,
    input  logic [4:0]  Rt_ex,
    input  logic        RegWrite_ex,
    input  logic        MemtoReg_ex,
    input  logic [4:0]  WriteReg_ex,
    input  logic        BranchTaken_ex,
    output logic        Stall,
    output logic        Flush_IFID,
    output logic        Flush_IDEX,
    output logic [1:0]  ForwardA,
    output logic [1:0]  ForwardB,
    output logic [15:0] StallCount,
    output logic [15:0] FlushCount
);

    shadow_t ex_s, mem_s, wb_s;

    assign ex_s = '{reg_write: RegWrite_ex, mem_to_reg: MemtoReg_ex, write_reg: WriteReg_ex};

    hazard_shadow u_shadow (
        .clk   (CLOCK),
        .rst_n (RESET_N),
        .ex_i  (ex_s),
        .mem_o (mem_s),
        .wb_o  (wb_s)
    );

    logic shadow_unused;
    assign shadow_unused = mem_s.mem_to_reg ^ wb_s.mem_to_reg;

    logic id_hit_ex;
    assign id_hit_ex = (UseRs_id && reg_hit(RegWrite_ex, WriteReg_ex, Rs_id)) ||
                       (UseRt_id && reg_hit(RegWrite_ex, WriteReg_ex, Rt_id));

    fwd_sel_e fwd_a, fwd_b;
    logic     hazard;

`ifdef HAZARD_FORWARD_EN
    always_comb begin
        fwd_a = FWD_RF;
        fwd_b = FWD_RF;
        if (reg_hit(mem_s.reg_write, mem_s.write_reg, Rs_ex))
            fwd_a = FWD_MEM;
        else if (reg_hit(wb_s.reg_write, wb_s.write_reg, Rs_ex))
            fwd_a = FWD_WB;
        if (reg_hit(mem_s.reg_write, mem_s.write_reg, Rt_ex))
            fwd_b = FWD_MEM;
        else if (reg_hit(wb_s.reg_write, wb_s.write_reg, Rt_ex))
            fwd_b = FWD_WB;
    end

    // Only a load cannot be bypassed in time; ALU results reach EX via the MEM path.
    assign hazard = id_hit_ex && MemtoReg_ex;
`else
    logic id_hit_mem;
    logic fwd_unused;

    assign id_hit_mem = (UseRs_id && reg_hit(mem_s.reg_write, mem_s.write_reg, Rs_id)) ||
                        (UseRt_id && reg_hit(mem_s.reg_write, mem_s.write_reg, Rt_id));
    assign fwd_a      = FWD_RF;
    assign fwd_b      = FWD_RF;
    // WB needs no stall: the register file writes in the first half-cycle.
    assign hazard     = id_hit_ex || id_hit_mem;
    assign fwd_unused = ^{Rs_ex, Rt_ex, MemtoReg_ex, wb_s};
`endif

    state_e state_q, state_d;
    logic   stall, flush_ifid, flush_idex;

    always_ff @(posedge CLOCK) begin
        if (!RESET_N) state_q <= RUN;
        else          state_q <= state_d;
    end

    // NOTE: every always_comb output gets a default first, so no path infers a latch.
    always_comb begin
        state_d    = state_q;
        stall      = 1'b0;
        flush_ifid = 1'b0;
        flush_idex = 1'b0;
        if (RESET_N) begin
            case (state_q)
                RUN: begin
                    if (BranchTaken_ex) begin
                        flush_ifid = 1'b1;
                        flush_idex = 1'b1;
                        state_d    = BFLUSH;
                    end else if (hazard) begin
                        stall      = 1'b1;
                        flush_idex = 1'b1;
                    end
                end
                BFLUSH:  state_d = RUN;
                default: state_d = RUN;
            endcase
        end
    end

    logic [15:0] stall_cnt_q, stall_cnt_d;
    logic [15:0] flush_cnt_q, flush_cnt_d;

    assign stall_cnt_d = sat_inc(stall_cnt_q, stall);
    assign flush_cnt_d = sat_inc(flush_cnt_q, flush_ifid);

    always_ff @(posedge CLOCK) begin
        if (!RESET_N) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign Stall      = stall;
    assign Flush_IFID = flush_ifid;
    assign Flush_IDEX = flush_idex;
    assign ForwardA   = RESET_N ? fwd_a : FWD_RF;
    assign ForwardB   = RESET_N ? fwd_b : FWD_RF;
    assign StallCount = stall_cnt_q;
    assign FlushCount = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: directed pipeline vectors push expected outputs,
// a negedge monitor pops and compares. Expectations follow HAZARD_FORWARD_EN.
module tb_hazard_ctrl;
    import hazard_pkg::*;

`ifdef HAZARD_FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic CLOCK   = 1'b0;
    logic RESET_N = 1'b0;

    always #5 CLOCK = ~CLOCK;

    hazard_if hif ();

    hazard_ctrl dut (
        .CLOCK          (CLOCK),
        .RESET_N        (RESET_N),
        .Rs_id          (hif.Rs_id),
        .Rt_id          (hif.Rt_id),
        .UseRs_id       (hif.UseRs_id),
        .UseRt_id       (hif.UseRt_id),
        .Rs_ex          (hif.Rs_ex),
        .Rt_ex          (hif.Rt_ex),
        .RegWrite_ex    (hif.RegWrite_ex),
        .MemtoReg_ex    (hif.MemtoReg_ex),
        .WriteReg_ex    (hif.WriteReg_ex),
        .BranchTaken_ex (hif.BranchTaken_ex),
        .Stall          (hif.Stall),
        .Flush_IFID     (hif.Flush_IFID),
        .Flush_IDEX     (hif.Flush_IDEX),
        .ForwardA       (hif.ForwardA),
        .ForwardB       (hif.ForwardB),
        .StallCount     (hif.StallCount),
        .FlushCount     (hif.FlushCount)
    );

    typedef struct packed {
        logic [4:0] rs_id, rt_id;
        logic       use_rs, use_rt;
        logic [4:0] rs_ex, rt_ex;
        logic       rw, m2r;
        logic [4:0] wr;
        logic       br;
        logic       rst_n;
    } vec_t;

    typedef struct packed {
        logic        stall, fi, fd;
        logic [1:0]  fa, fb;
        logic [15:0] sc, fc;
    } exp_t;

    exp_t        sb_q[$];
    string       name_q[$];
    int          n_checks = 0;
    int          n_pass   = 0;
    logic [15:0] m_sc, m_fc;

    function automatic vec_t mk(input logic [4:0] rs_id, input logic [4:0] rt_id,
                                input logic use_rs, input logic use_rt,
                                input logic [4:0] rs_ex, input logic [4:0] rt_ex,
                                input logic rw, input logic m2r, input logic [4:0] wr,
                                input logic br);
        vec_t v;
        v = '{rs_id: rs_id, rt_id: rt_id, use_rs: use_rs, use_rt: use_rt,
              rs_ex: rs_ex, rt_ex: rt_ex, rw: rw, m2r: m2r, wr: wr, br: br, rst_n: 1'b1};
        return v;
    endfunction

    function automatic logic [1:0] f(input logic [1:0] sel);
        return FWD ? sel : 2'b00;
    endfunction

    // Drive one cycle; the expected counters are the totals from earlier cycles.
    task automatic step(input vec_t v, input logic stall, input logic fi, input logic fd,
                        input logic [1:0] fa, input logic [1:0] fb,
                        input bit chk, input string name);
        exp_t e;
        @(posedge CLOCK);
        #1;
        RESET_N            = v.rst_n;
        hif.Rs_id          = v.rs_id;
        hif.Rt_id          = v.rt_id;
        hif.UseRs_id       = v.use_rs;
        hif.UseRt_id       = v.use_rt;
        hif.Rs_ex          = v.rs_ex;
        hif.Rt_ex          = v.rt_ex;
        hif.RegWrite_ex    = v.rw;
        hif.MemtoReg_ex    = v.m2r;
        hif.WriteReg_ex    = v.wr;
        hif.BranchTaken_ex = v.br;
        if (chk) begin
            e = '{stall: stall, fi: fi, fd: fd, fa: fa, fb: fb, sc: m_sc, fc: m_fc};
            sb_q.push_back(e);
            name_q.push_back(name);
        end
        if (!v.rst_n) begin
            m_sc = 16'h0000;
            m_fc = 16'h0000;
        end else begin
            if (stall && m_sc != 16'hFFFF) m_sc = m_sc + 16'd1;
            if (fi && m_fc != 16'hFFFF)    m_fc = m_fc + 16'd1;
        end
    endtask

    initial begin : monitor
        exp_t  e, got;
        string nm;
        forever begin
            @(negedge CLOCK);
            if (sb_q.size() > 0) begin
                e  = sb_q.pop_front();
                nm = name_q.pop_front();
                got = '{stall: hif.Stall, fi: hif.Flush_IFID, fd: hif.Flush_IDEX,
                        fa: hif.ForwardA, fb: hif.ForwardB,
                        sc: hif.StallCount, fc: hif.FlushCount};
                n_checks++;
                if (got === e) n_pass++;
                else $display("FAIL %s: got stall=%b fifd=%b%b fa=%b fb=%b sc=%h fc=%h, want stall=%b fifd=%b%b fa=%b fb=%b sc=%h fc=%h",
                              nm, got.stall, got.fi, got.fd, got.fa, got.fb, got.sc, got.fc,
                              e.stall, e.fi, e.fd, e.fa, e.fb, e.sc, e.fc);
            end
        end
    end

    initial begin : stimulus
        vec_t v, lu, lu_br, nop;
        nop   = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        lu    = mk(8, 8, 1, 1, 9, 8, 1, 1, 8, 0);
        lu_br = mk(8, 8, 1, 1, 9, 8, 1, 1, 8, 1);

        // Reset with a load-use hit and a taken branch present: outputs must stay quiet.
        v = lu_br; v.rst_n = 1'b0;
        step(v, 0, 0, 0, 2'b00, 2'b00, 0, "rst_first");
        step(v, 0, 0, 0, 2'b00, 2'b00, 1, "reset_outputs");

        // Forwarding: add $3,$1,$2 then dependents; $0 never forwards.
        step(mk(0, 0, 0, 0, 1, 2, 1, 0, 3, 0), 0, 0, 0, 2'b00, 2'b00, 1, "add_ex");
        step(mk(0, 0, 0, 0, 3, 5, 1, 0, 4, 0), 0, 0, 0, f(2'b10), 2'b00, 1, "fwd_mem_a");
        step(mk(0, 0, 0, 0, 3, 4, 1, 0, 6, 0), 0, 0, 0, f(2'b01), f(2'b10), 1, "fwd_wb_a_mem_b");
        step(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0), 0, 0, 0, 2'b00, 2'b00, 1, "src_zero");
        step(mk(0, 0, 0, 0, 0, 6, 1, 0, 6, 0), 0, 0, 0, 2'b00, f(2'b01), 1, "mem_r0_wb_b");
        step(mk(0, 0, 0, 0, 0, 0, 1, 0, 6, 0), 0, 0, 0, 2'b00, 2'b00, 1, "wb_r0");
        step(mk(0, 0, 0, 0, 6, 6, 0, 0, 6, 0), 0, 0, 0, f(2'b10), f(2'b10), 1, "mem_over_wb");
        step(mk(0, 0, 0, 0, 6, 0, 1, 0, 0, 0), 0, 0, 0, f(2'b01), 2'b00, 1, "mem_not_writing");
        step(nop, 0, 0, 0, 2'b00, 2'b00, 1, "mem_wr0_no_fwd");
        step(nop, 0, 0, 0, 2'b00, 2'b00, 1, "wb_wr0_no_fwd");

        // Load-use: lw $8,0($9) in EX, add $10,$8,$8 in decode.
        step(lu, 1, 0, 1, 2'b00, 2'b00, 1, "load_use");
        step(mk(0, 0, 0, 0, 8, 8, 1, 0, 10, 0), 0, 0, 0, f(2'b10), f(2'b10), 1, "after_load_fwd");
        step(nop, 0, 0, 0, 2'b00, 2'b00, 1, "drain_a");
        step(nop, 0, 0, 0, 2'b00, 2'b00, 1, "drain_b");

        // Branch and load-use together: branch wins, then one quiet BFLUSH cycle.
        step(lu_br, 0, 1, 1, 2'b00, 2'b00, 1, "branch_wins");
        step(lu_br, 0, 0, 0, 2'b00, f(2'b10), 1, "bflush_quiet");
        step(lu, 1, 0, 1, 2'b00, f(2'b10), 1, "run_again");

        // Hold the load-use hit to walk StallCount up to saturation.
        while (m_sc != 16'hFFFE) step(lu, 1, 0, 1, 2'b00, f(2'b10), 0, "");
        step(lu, 1, 0, 1, 2'b00, f(2'b10), 1, "sat_fffe");
        step(lu, 1, 0, 1, 2'b00, f(2'b10), 1, "sat_ffff");
        step(lu, 1, 0, 1, 2'b00, f(2'b10), 1, "sat_hold");

        // Reset while in BFLUSH: counters clear and the next cycle is in RUN.
        step(lu_br, 0, 1, 1, 2'b00, f(2'b10), 1, "branch_pre_reset");
        v = lu_br; v.rst_n = 1'b0;
        step(v, 0, 0, 0, 2'b00, 2'b00, 1, "reset_in_bflush");
        step(lu, 1, 0, 1, 2'b00, 2'b00, 1, "run_after_reset");
        step(nop, 0, 0, 0, 2'b00, 2'b00, 1, "drain_c");
        step(nop, 0, 0, 0, 2'b00, 2'b00, 1, "drain_d");

        // add $3 then dependent sub $4,$3,$5 waiting in decode.
        step(mk(3, 5, 1, 1, 1, 2, 1, 0, 3, 0), !FWD, 0, !FWD, 2'b00, 2'b00, 1, "dep_ex");
        step(mk(3, 5, 1, 1, 0, 0, 0, 0, 0, 0), !FWD, 0, !FWD, 2'b00, 2'b00, 1, "dep_mem");
        step(mk(3, 5, 1, 1, 0, 0, 0, 0, 0, 0), 0, 0, 0, 2'b00, 2'b00, 1, "dep_wb");
        step(mk(0, 0, 0, 0, 3, 5, 1, 0, 4, 0), 0, 0, 0, 2'b00, 2'b00, 1, "dep_issue");

        for (int i = 0; i < 5 && sb_q.size() > 0; i++) begin
            @(negedge CLOCK);
            #1;
        end
        if (sb_q.size() > 0) begin
            n_checks++;
            $display("FAIL drain: %0d expected entries left, want 0", sb_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 The block SHALL have exactly one clock and a synchronous, active-low reset, named CLOCK and RESET_N, listed first in the port list.
REQ-002 The ports SHALL be, one per line (name, direction, width, meaning):
- CLOCK  in  1  rising-edge clock.
- RESET_N  in  1  synchronous reset, active-low.
- Rs_id, Rt_id  in  5 each  source registers of the instruction in decode.
- UseRs_id, UseRt_id  in  1 each  decode instruction reads Rs / Rt.
- Rs_ex, Rt_ex  in  5 each  source registers of the instruction in EX, from ID_EX.
- RegWrite_ex, MemtoReg_ex  in  1 each  EX instruction writes the register file / is a load.
- WriteReg_ex  in  5  EX destination register, after the RegDst mux.
- BranchTaken_ex  in  1  branch resolved taken in EX.
- Stall  out  1  hold PC and IF_ID.
- Flush_IFID, Flush_IDEX  out  1 each  clear the IF_ID / ID_EX control fields.
- ForwardA, ForwardB  out  2 each  ALU SrcA / SrcB source select: 00 register file, 10 MEM result, 01 WB result.
- StallCount, FlushCount  out  16 each  saturating event counters.

Function
REQ-003 The block SHALL keep MEM and WB shadow registers (RegWrite, MemtoReg, WriteReg) and shift them every cycle: EX inputs into MEM, MEM into WB.
REQ-004 Forwarding SHALL select 10 when the MEM shadow has RegWrite=1, WriteReg!=0 and WriteReg equals Rs_ex (or Rt_ex for B).
REQ-005 Forwarding SHALL otherwise select 01 when the WB shadow meets the same condition; MEM has priority over WB.
REQ-006 Register 0 SHALL never be forwarded and SHALL never cause a stall.
REQ-007 Load-use stall SHALL assert Stall=1 and Flush_IDEX=1 combinationally for one cycle when RegWrite_ex=1, MemtoReg_ex=1 and WriteReg_ex matches a used decode source (Rs_id with UseRs_id, or Rt_id with UseRt_id).
REQ-008 The FSM SHALL have states RUN and BFLUSH.
REQ-009 In RUN, BranchTaken_ex=1 SHALL assert Flush_IFID=1 and Flush_IDEX=1 in the same cycle and move the FSM to BFLUSH.
REQ-010 BFLUSH SHALL last one cycle, SHALL suppress Stall and ignore BranchTaken_ex, and SHALL return to RUN.
REQ-011 When a branch flush and a load-use stall coincide, the branch SHALL win: Stall=0, both flushes=1.
REQ-012 StallCount SHALL increment on every cycle with Stall=1, and FlushCount SHALL increment on every cycle with Flush_IFID=1.
REQ-013 Both counters SHALL saturate at 16'hFFFF and never wrap.

Reset
REQ-014 When RESET_N=0 at a rising edge, the FSM SHALL go to RUN, the shadow RegWrite and MemtoReg bits SHALL clear to 0, WriteReg SHALL clear to 0, and both counters SHALL clear to 0.
REQ-015 While RESET_N=0, Stall, Flush_IFID, Flush_IDEX, ForwardA and ForwardB SHALL be 0.
REQ-016 A reset during BFLUSH SHALL abort the flush; the first cycle after reset SHALL be in RUN.

Configuration
REQ-017 Macro HAZARD_FORWARD_EN defined: behaviour SHALL be as in REQ-004 to REQ-007.
REQ-018 Macro HAZARD_FORWARD_EN undefined: ForwardA and ForwardB SHALL be tied to 00.
REQ-019 Without HAZARD_FORWARD_EN, Stall=1 and Flush_IDEX=1 SHALL assert whenever a used decode source matches a writing, nonzero destination in EX or in MEM. The register file handles WB by writing before it is read.

Structure
REQ-020 The forward-select encodings (FWD_RF, FWD_MEM, FWD_WB) and the FSM state encodings SHALL live in the shared package hazard_pkg.
REQ-021 The MEM/WB shadow shift logic SHALL be the sub-module hazard_shadow.
REQ-022 Comparison and FSM logic SHALL stay in hazard_ctrl.

Verification
REQ-023 The bench SHALL cover all of the following scenarios:
- add $3,$1,$2 in EX, then sub $4,$3,$5 in EX next cycle -> ForwardA=10.
- Same add, sub two instructions later -> ForwardA=01; with WriteReg=0 -> ForwardA=00.
- lw $8,0($9) in EX, decode add $10,$8,$8 -> Stall=1 and Flush_IDEX=1 for exactly one cycle; next cycle ForwardA=10.
- BranchTaken_ex=1 together with a load-use hit -> Stall=0, both flushes=1, BFLUSH for one cycle, FlushCount increments by 1.
- StallCount preset to 16'hFFFE by forcing two stalls -> value stays at 16'hFFFF; RESET_N=0 in BFLUSH -> counters 0, state RUN.
- HAZARD_FORWARD_EN undefined, add $3 then a dependent sub -> Stall=1 for 2 cycles, ForwardA=00 throughout.
